key_event: RTL and testbench

Press-event classifier that sits directly downstream of `debouncing`. It consumes the debounced button level plus the `clken` tick, and turns them into single-cycle event pulses for the application logic: press, release, short click, long press and auto-repeat. It also maintains a wrapping press counter. Hold-time measurement is counted in `clk_flag` ticks, so it shares the same time base as the debouncer.

---
 rtl/key_event.sv | 132 +++++++++++++
 tb/tb_key_event.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// Press-event classifier fed by the debounced button level and the clken tick.
// Emits press/release/click/long/repeat pulses and keeps a wrapping press count.
module key_event #(
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int TICK_W       = 8,
  parameter int CNT_W        = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clk_flag,
  input  logic             i_btn,
  output logic             o_press,
  output logic             o_release,
  output logic             o_click,
  output logic             o_long,
  output logic             o_repeat,
  output logic             o_held,
  output logic [CNT_W-1:0] o_press_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SHORT,
    LONG
  } state_t;

  localparam logic [TICK_W-1:0] LONG_M1 = TICK_W'(LONG_TICKS - 1);
  localparam logic [TICK_W-1:0] REP_M1  = TICK_W'(REPEAT_TICKS - 1);

  state_t            state;
  state_t            state_nx;
  logic [TICK_W-1:0] tcnt;
  logic [TICK_W-1:0] tcnt_nx;
  logic              btn_q;
  logic              press;
  logic              rel;
  logic              press_nx;
  logic              release_nx;
  logic              click_nx;
  logic              long_nx;
  logic              repeat_nx;
  logic              held_nx;
  logic [CNT_W-1:0]  cnt_nx;

  assign press = i_btn & ~btn_q;
  assign rel   = ~i_btn & btn_q;

  // Release wins over a threshold landing in the same cycle.
  always_comb begin
    state_nx   = state;
    tcnt_nx    = tcnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    click_nx   = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;
    cnt_nx     = o_press_cnt;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_nx = SHORT;
          tcnt_nx  = '0;
          press_nx = 1'b1;
          cnt_nx   = o_press_cnt + 1'b1;
        end
      end
      SHORT: begin
        if (rel) begin
          state_nx   = IDLE;
          tcnt_nx    = '0;
          release_nx = 1'b1;
          click_nx   = 1'b1;
        end else if (clk_flag) begin
          if (tcnt == LONG_M1) begin
            state_nx = LONG;
            tcnt_nx  = '0;
            long_nx  = 1'b1;
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end
      end
      LONG: begin
        if (rel) begin
          state_nx   = IDLE;
          tcnt_nx    = '0;
          release_nx = 1'b1;
        end else if (clk_flag) begin
          if (tcnt == REP_M1) begin
            tcnt_nx   = '0;
            repeat_nx = 1'b1;
          end else begin
            tcnt_nx = tcnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        tcnt_nx  = '0;
      end
    endcase
    held_nx = (state_nx != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      btn_q       <= 1'b0;
      o_press     <= 1'b0;
      o_release   <= 1'b0;
      o_click     <= 1'b0;
      o_long      <= 1'b0;
      o_repeat    <= 1'b0;
      o_held      <= 1'b0;
      o_press_cnt <= '0;
    end else begin
      state       <= state_nx;
      tcnt        <= tcnt_nx;
      btn_q       <= i_btn;
      o_press     <= press_nx;
      o_release   <= release_nx;
      o_click     <= click_nx;
      o_long      <= long_nx;
      o_repeat    <= repeat_nx;
      o_held      <= held_nx;
      o_press_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: directed scenarios plus random button traffic,
// checked every cycle against a hold-time reference model.
module tb_key_event;

  localparam int LONG = 4;
  localparam int REP  = 2;
  localparam int CW   = 2;

  logic          sys_clk;
  logic          sys_rst;
  logic          clk_flag;
  logic          i_btn;
  logic          o_press;
  logic          o_release;
  logic          o_click;
  logic          o_long;
  logic          o_repeat;
  logic          o_held;
  logic [CW-1:0] o_press_cnt;

  key_event #(
    .LONG_TICKS  (LONG),
    .REPEAT_TICKS(REP),
    .TICK_W      (8),
    .CNT_W       (CW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .clk_flag   (clk_flag),
    .i_btn      (i_btn),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_click    (o_click),
    .o_long     (o_long),
    .o_repeat   (o_repeat),
    .o_held     (o_held),
    .o_press_cnt(o_press_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cnum   = 0;

  // Reference model: hold time in ticks since the press.
  bit m_prev;
  int m_ticks;
  int m_cnt;
  bit e_press, e_release, e_click, e_long, e_repeat, e_held;

  int n_long;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cnum);
    end
  endtask

  task automatic model_step();
    e_press   = 0;
    e_release = 0;
    e_click   = 0;
    e_long    = 0;
    e_repeat  = 0;
    if (sys_rst) begin
      m_prev  = 0;
      m_ticks = 0;
      m_cnt   = 0;
      e_held  = 0;
    end else begin
      if (i_btn && !m_prev) begin
        e_press = 1;
        m_cnt   = (m_cnt + 1) % (1 << CW);
        m_ticks = 0;
      end else if (!i_btn && m_prev) begin
        e_release = 1;
        e_click   = (m_ticks < LONG);
      end else if (m_prev && clk_flag) begin
        m_ticks++;
        if (m_ticks == LONG) e_long = 1;
        else if (m_ticks > LONG && (m_ticks - LONG) % REP == 0) e_repeat = 1;
      end
      m_prev = i_btn;
      e_held = i_btn;
    end
  endtask

  task automatic compare_all();
    check("press", int'(o_press), int'(e_press));
    check("release", int'(o_release), int'(e_release));
    check("click", int'(o_click), int'(e_click));
    check("long", int'(o_long), int'(e_long));
    check("repeat", int'(o_repeat), int'(e_repeat));
    check("held", int'(o_held), int'(e_held));
    check("press_cnt", int'(o_press_cnt), m_cnt);
    check("onehot", int'($countones({o_press, o_release, o_long, o_repeat}) <= 1), 1);
    check("click_rel", int'(o_click & ~o_release), 0);
    if (o_long === 1'b1) n_long++;
  endtask

  task automatic cyc(input logic b, input logic r);
    i_btn    = b;
    sys_rst  = r;
    clk_flag = (cnum % 5 == 4);
    cnum++;
    @(posedge sys_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b0);
  endtask

  initial begin
    int reached;
    i_btn    = 1'b0;
    sys_rst  = 1'b1;
    clk_flag = 1'b0;
    m_prev   = 0;
    m_ticks  = 0;
    m_cnt    = 0;
    e_held   = 0;
    n_long   = 0;
    #1;

    // Reset
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    check("rst_cnt", int'(o_press_cnt), 0);
    hold(1'b0, 4);

    // Short click: 12 cycles high
    hold(1'b1, 1);
    check("sc_press", int'(o_press), 1);
    hold(1'b1, 11);
    hold(1'b0, 1);
    check("sc_click", int'(o_click), 1);
    check("sc_cnt", int'(o_press_cnt), 1);
    hold(1'b0, 5);

    // Long hold with repeats
    n_long = 0;
    hold(1'b1, 45);
    check("lh_long_once", n_long, 1);
    hold(1'b0, 1);
    check("lh_release", int'(o_release), 1);
    check("lh_noclick", int'(o_click), 0);
    hold(1'b0, 5);

    // Release on the cycle the 4th tick would cross the threshold
    n_long  = 0;
    reached = 0;
    hold(1'b1, 1);
    for (int i = 0; i < 100; i++) begin
      if (m_ticks == LONG - 1 && cnum % 5 == 4) begin
        reached = 1;
        break;
      end
      cyc(1'b1, 1'b0);
    end
    check("coinc_reached", reached, 1);
    hold(1'b0, 1);
    check("coinc_release", int'(o_release), 1);
    check("coinc_click", int'(o_click), 1);
    check("coinc_nolong", n_long, 0);
    hold(1'b0, 5);

    // Counter wrap over 5 short presses
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 3);
      hold(1'b0, 3);
    end

    // Reset mid-hold while in long-press
    hold(1'b1, 30);
    check("mh_held", int'(o_held), 1);
    cyc(1'b1, 1'b1);
    check("mh_norel", int'(o_release), 0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("mh_press", int'(o_press), 1);
    check("mh_cnt", int'(o_press_cnt), 1);
    hold(1'b1, 3);
    hold(1'b0, 4);

    // Random traffic
    for (int s = 0; s < 300; s++) begin
      hold(1'b1, int'($urandom_range(1, 40)));
      if ($urandom_range(0, 19) == 0) cyc(1'b1, 1'b1);
      hold(1'b0, int'($urandom_range(1, 10)));
      if ($urandom_range(0, 19) == 0) cyc($urandom_range(0, 1) == 1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
